// File: rtl/rtt_header_buffer.sv
// RTT response header buffer: captures the SPI-written header words into a local register
// file and replays them as pulse symbols over a valid/ready stream.
module rtt_header_buffer #(
    parameter int unsigned WORD_NUM = 8,
    parameter int unsigned SYM_W    = 5
) (
    input  logic             logic_clk_in,
    input  logic             logic_rst_n,
    input  logic [3:0]       spi_ram_addr_in,
    input  logic [31:0]      spi_ram_data_in,
    input  logic             spi_ram_wr_in,
    input  logic             hdr_start_in,
    input  logic             hdr_abort_in,
    input  logic             err_clr_in,
    input  logic             sym_ready_in,
    output logic             sym_valid_out,
    output logic [SYM_W-1:0] sym_data_out,
    output logic             sym_last_out,
    output logic             hdr_ready_out,
    output logic [3:0]       word_cnt_out,
    output logic [1:0]       hdr_err_out,
    output logic [63:0]      debug_signal
);
    localparam int unsigned SYM_NUM = WORD_NUM * 4;
    localparam int unsigned IDX_W   = $clog2(SYM_NUM);
    localparam int unsigned AW      = $clog2(WORD_NUM);
    localparam int unsigned DBG_W   = 2 + WORD_NUM + IDX_W + 3 + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYM_NUM - 1);
    localparam logic [IDX_W-1:0] PREV_IDX = IDX_W'(SYM_NUM - 2);

    typedef enum logic [1:0] {StIdle, StFill, StFull, StSend} state_e;

    state_e              r_state, w_state_nxt;
    logic [31:0]         r_mem [WORD_NUM];
    logic [WORD_NUM-1:0] r_mask, w_mask_nxt;
    logic [IDX_W-1:0]    r_sym_idx, w_sym_idx_nxt;
    logic                r_sym_valid, w_sym_valid_nxt;
    logic                r_sym_last, w_sym_last_nxt;
    logic [SYM_W-1:0]    r_sym_data, w_sym_data_nxt;
    logic [1:0]          r_err, w_err_set;
    logic                r_wr_sync1, r_wr_sync2, r_wr_prev;
    logic                w_wr_pulse, w_addr_ok, w_mem_we;
    logic [AW-1:0]       w_wr_idx;
    logic [IDX_W-1:0]    w_fetch_idx;
    logic [SYM_W-1:0]    w_fetch_sym;

    // The write strobe lives in the spi_sck domain; addr/data are held for a whole SPI word.
    always_ff @(posedge logic_clk_in or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            r_wr_sync1 <= 1'b0;
            r_wr_sync2 <= 1'b0;
            r_wr_prev  <= 1'b0;
        end else begin
            r_wr_sync1 <= spi_ram_wr_in;
            r_wr_sync2 <= r_wr_sync1;
            r_wr_prev  <= r_wr_sync2;
        end
    end

    assign w_wr_pulse = r_wr_sync2 & ~r_wr_prev;
    assign w_addr_ok  = (spi_ram_addr_in != 4'd0) && (spi_ram_addr_in <= 4'(WORD_NUM));
    assign w_wr_idx   = AW'(spi_ram_addr_in - 4'd1);

    // Symbol to present after the next state change: 0 on start, idx+1 while sending.
    assign w_fetch_idx = (r_state == StSend) ? r_sym_idx + IDX_W'(1) : '0;

    always_comb begin
        w_fetch_sym = '0;
        unique case (w_fetch_idx[1:0])
            2'd0: w_fetch_sym = r_mem[w_fetch_idx[IDX_W-1:2]][24 +: SYM_W];
            2'd1: w_fetch_sym = r_mem[w_fetch_idx[IDX_W-1:2]][16 +: SYM_W];
            2'd2: w_fetch_sym = r_mem[w_fetch_idx[IDX_W-1:2]][8 +: SYM_W];
            2'd3: w_fetch_sym = r_mem[w_fetch_idx[IDX_W-1:2]][0 +: SYM_W];
            default: w_fetch_sym = '0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_sym_idx_nxt   = r_sym_idx;
        w_sym_valid_nxt = r_sym_valid;
        w_sym_last_nxt  = r_sym_last;
        w_sym_data_nxt  = r_sym_data;
        w_mem_we        = 1'b0;
        w_err_set       = 2'b00;
        if (hdr_abort_in) begin
            w_state_nxt     = StIdle;
            w_mask_nxt      = '0;
            w_sym_idx_nxt   = '0;
            w_sym_valid_nxt = 1'b0;
            w_sym_last_nxt  = 1'b0;
            w_sym_data_nxt  = '0;
        end else begin
            unique case (r_state)
                StIdle, StFill: begin
                    if (w_wr_pulse && w_addr_ok) begin
                        w_mem_we             = 1'b1;
                        w_mask_nxt[w_wr_idx] = 1'b1;
                        w_state_nxt          = StFill;
                    end else if (w_wr_pulse) begin
                        w_err_set[0] = 1'b1;
                    end
                    if (hdr_start_in) begin
                        w_err_set[1] = 1'b1;
                    end
                    if (r_state == StFill && (&r_mask)) begin
                        w_state_nxt = StFull;
                    end
                end
                StFull: begin
                    if (w_wr_pulse) begin
                        w_err_set[0] = 1'b1;
                    end
                    if (hdr_start_in) begin
                        w_state_nxt     = StSend;
                        w_sym_idx_nxt   = '0;
                        w_sym_valid_nxt = 1'b1;
                        w_sym_last_nxt  = 1'b0;
                        w_sym_data_nxt  = w_fetch_sym;
                    end
                end
                StSend: begin
                    if (w_wr_pulse) begin
                        w_err_set[0] = 1'b1;
                    end
                    if (r_sym_valid && sym_ready_in) begin
                        if (r_sym_idx == LAST_IDX) begin
                            w_state_nxt     = StIdle;
                            w_mask_nxt      = '0;
                            w_sym_idx_nxt   = '0;
                            w_sym_valid_nxt = 1'b0;
                            w_sym_last_nxt  = 1'b0;
                            w_sym_data_nxt  = '0;
                        end else begin
                            w_sym_idx_nxt  = r_sym_idx + IDX_W'(1);
                            w_sym_last_nxt = (r_sym_idx == PREV_IDX);
                            w_sym_data_nxt = w_fetch_sym;
                        end
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge logic_clk_in or negedge logic_rst_n) begin
        if (!logic_rst_n) begin
            r_state     <= StIdle;
            r_mask      <= '0;
            r_sym_idx   <= '0;
            r_sym_valid <= 1'b0;
            r_sym_last  <= 1'b0;
            r_sym_data  <= '0;
            r_err       <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_sym_idx   <= w_sym_idx_nxt;
            r_sym_valid <= w_sym_valid_nxt;
            r_sym_last  <= w_sym_last_nxt;
            r_sym_data  <= w_sym_data_nxt;
            // A new error in the clearing cycle keeps its bit set.
            r_err       <= (err_clr_in ? 2'b00 : r_err) | w_err_set;
        end
    end

    always_ff @(posedge logic_clk_in) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= spi_ram_data_in;
        end
    end

    always_comb begin
        word_cnt_out = '0;
        for (int i = 0; i < WORD_NUM; i++) begin
            word_cnt_out = word_cnt_out + {3'b000, r_mask[i]};
        end
    end

    assign sym_valid_out = r_sym_valid;
    assign sym_data_out  = r_sym_data;
    assign sym_last_out  = r_sym_last;
    assign hdr_ready_out = (r_state == StFull);
    assign hdr_err_out   = r_err;
    assign debug_signal  = {{(64 - DBG_W){1'b0}}, r_state, r_mask, r_sym_idx,
                            r_wr_sync1, r_wr_sync2, r_wr_prev, r_err};

endmodule

// File: tb/tb_rtt_header_buffer.sv
// Self-checking bench for rtt_header_buffer: randomized fills and ready patterns checked
// against a word-level model of the header and its symbol sequence.
module tb_rtt_header_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        wr, start, abort, err_clr, ready;
    logic        valid, last, hdr_ready;
    logic [4:0]  sdata;
    logic [3:0]  cnt;
    logic [1:0]  err;
    logic [63:0] dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_mem [8];
    logic [7:0]  exp_mask;
    logic [1:0]  exp_err;
    bit          exp_locked;

    always #5 clk = ~clk;

    rtt_header_buffer dut (
        .logic_clk_in   (clk),
        .logic_rst_n    (rst_n),
        .spi_ram_addr_in(addr),
        .spi_ram_data_in(wdata),
        .spi_ram_wr_in  (wr),
        .hdr_start_in   (start),
        .hdr_abort_in   (abort),
        .err_clr_in     (err_clr),
        .sym_ready_in   (ready),
        .sym_valid_out  (valid),
        .sym_data_out   (sdata),
        .sym_last_out   (last),
        .hdr_ready_out  (hdr_ready),
        .word_cnt_out   (cnt),
        .hdr_err_out    (err),
        .debug_signal   (dbg)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] exp_sym(input int i);
        return 5'((exp_mem[i / 4] >> (8 * (3 - (i % 4)))) & 32'h1f);
    endfunction

    function automatic int exp_cnt();
        return $countones(exp_mask);
    endfunction

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        if (a == 4'd0 || a > 4'd8 || exp_locked) begin
            exp_err[0] = 1'b1;
        end else begin
            exp_mem[a - 4'd1]  = d;
            exp_mask[a - 4'd1] = 1'b1;
        end
    endtask

    task automatic spi_write(input logic [3:0] a, input logic [31:0] d, input bit chk_lat);
        @(posedge clk);
        #1;
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        if (chk_lat) begin
            @(posedge clk); #1;
            check_eq("lat_edge1", cnt, exp_cnt());
            @(posedge clk); #1;
            check_eq("lat_edge2", cnt, exp_cnt());
            model_write(a, d);
            @(posedge clk); #1;
            check_eq("lat_edge3", cnt, exp_cnt());
            @(posedge clk);
        end else begin
            repeat (4) @(posedge clk);
            model_write(a, d);
        end
        #1 wr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (exp_mask == 8'hff) exp_locked = 1'b1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_err = 2'b00;
    endtask

    task automatic fill_random();
        int order [8];
        for (int i = 0; i < 8; i++) order[i] = i + 1;
        for (int i = 7; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        // Junk write first; the shuffled fill must overwrite it silently.
        spi_write(4'(order[7]), $urandom, 1'b0);
        for (int i = 0; i < 8; i++) spi_write(4'(order[i]), $urandom, 1'b0);
        check_eq("fill_cnt", cnt, 8);
        check_eq("fill_ready", hdr_ready, 1);
        check_eq("fill_err", err, exp_err);
    endtask

    task automatic replay(input bit rand_ready);
        int  n = 0;
        int  cycles = 0;
        bit  stalled = 1'b0;
        logic [4:0] held = '0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("start_valid", valid, 1);
        check_eq("start_hdr_ready", hdr_ready, 0);
        while (n < 32 && cycles < 400) begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (stalled) begin
                check_eq("hold_valid", valid, 1);
                check_eq("hold_data", sdata, held);
            end
            if (!rand_ready) check_eq("stream_valid", valid, 1);
            if (valid) check_eq("send_hdr_ready", hdr_ready, 0);
            if (valid && ready) begin
                check_eq("sym_data", sdata, exp_sym(n));
                check_eq("sym_last", last, (n == 31));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = valid;
                held    = sdata;
            end
            @(posedge clk); #1;
            cycles++;
        end
        check_eq("replay_count", n, 32);
        if (!rand_ready) check_eq("replay_cycles", cycles, 32);
        ready = 1'b0;
        exp_mask   = '0;
        exp_locked = 1'b0;
        check_eq("post_valid", valid, 0);
        check_eq("post_cnt", cnt, 0);
        check_eq("post_hdr_ready", hdr_ready, 0);
        check_eq("post_err", err, exp_err);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_data"}, sdata, 0);
        check_eq({tag, "_last"}, last, 0);
        check_eq({tag, "_hdr_ready"}, hdr_ready, 0);
        check_eq({tag, "_cnt"}, cnt, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_debug"}, dbg, 0);
    endtask

    initial begin
        logic [31:0] fixed [8];
        fixed[0] = 32'h5555aaaa; fixed[1] = 32'h12345678;
        fixed[2] = 32'hdeadbeef; fixed[3] = 32'h0f0f0f0f;
        fixed[4] = 32'ha5a5a5a5; fixed[5] = 32'hffff0000;
        fixed[6] = 32'h13579bdf; fixed[7] = 32'h0000001f;

        rst_n = 1'b0; addr = '0; wdata = '0; wr = 1'b0;
        start = 1'b0; abort = 1'b0; err_clr = 1'b0; ready = 1'b0;
        exp_mask = '0; exp_err = 2'b00; exp_locked = 1'b0;
        #2;
        check_outputs_zero("rst_in");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_outputs_zero("rst_out");

        // Fixed header, ready held high; first write also checks commit latency.
        for (int i = 0; i < 8; i++) spi_write(4'(i + 1), fixed[i], (i == 0));
        check_eq("fixed_cnt", cnt, 8);
        check_eq("fixed_ready", hdr_ready, 1);
        check_eq("sym0", exp_sym(0), 5'h15);
        replay(1'b0);

        // Same header in shuffled order, random ready.
        for (int i = 7; i >= 0; i--) spi_write(4'(i + 1), fixed[i], 1'b0);
        check_eq("fixed2_cnt", cnt, 8);
        replay(1'b1);

        // Bad addresses, then start on a 7-word header.
        spi_write(4'd0, 32'h11111111, 1'b0);
        spi_write(4'd9, 32'h22222222, 1'b0);
        check_eq("badaddr_err", err, exp_err);
        check_eq("badaddr_cnt", cnt, 0);
        for (int i = 0; i < 7; i++) spi_write(4'(i + 1), $urandom, 1'b0);
        check_eq("seven_cnt", cnt, 7);
        @(posedge clk); #1;
        start = 1'b1;
        exp_err[1] = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("early_start_valid", valid, 0);
            @(posedge clk); #1;
        end
        check_eq("early_start_err", err, 2'b11);
        check_eq("early_start_ready", hdr_ready, 0);
        pulse_clr();
        check_eq("clr_err", err, 2'b00);
        spi_write(4'd8, $urandom, 1'b1);
        check_eq("eighth_ready", hdr_ready, 1);

        // Rewrite while FULL is dropped and flagged.
        spi_write(4'd3, 32'hffffffff, 1'b0);
        check_eq("protect_err", err, 2'b01);
        check_eq("protect_cnt", cnt, 8);
        replay(1'b0);
        pulse_clr();
        check_eq("clr_err2", err, 2'b00);

        // Abort at symbol 5 together with a start.
        fill_random();
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_eq("pre_abort_sym", sdata, exp_sym(k));
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        ready = 1'b0;
        exp_mask   = '0;
        exp_locked = 1'b0;
        check_eq("abort_valid", valid, 0);
        check_eq("abort_cnt", cnt, 0);
        check_eq("abort_ready", hdr_ready, 0);
        pulse_clr();
        fill_random();
        replay(1'b1);

        // Asynchronous reset while presenting symbol 10.
        fill_random();
        @(posedge clk); #1;
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("pre_reset_sym", sdata, exp_sym(10));
        #1 rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_rst");
        ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_mask = '0; exp_err = 2'b00; exp_locked = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_cnt", cnt, 0);
        check_eq("post_rst_valid", valid, 0);
        spi_write(4'd5, $urandom, 1'b0);
        check_eq("post_rst_write_cnt", cnt, 1);
        check_eq("post_rst_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rtt_header_buffer.md
# rtt_header_buffer

Collects the eight 32-bit RTT response header words written by the DSP over SPI (addresses 1–8 from the SPI capture stage) into a local register file in the logic clock domain. On a slot start request it replays the header as 32 five-bit pulse symbols over a valid/ready stream toward the Link16 transmit path. It sits directly downstream of the SPI capture stage and upstream of the pulse symbol mapper.

## Interface
- WORD_NUM, 8, header words per frame (SPI addresses 1..WORD_NUM)
- SYM_W, 5, useful bits per pulse symbol (low bits of each byte)

- logic_clk_in  in  1  logic clock; frequency ≥ 4× spi_sck
- logic_rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- spi_ram_addr_in  in  4  word address from SPI stage, valid 1..8
- spi_ram_data_in  in  32  word data from SPI stage; stable around strobe
- spi_ram_wr_in  in  1  write strobe, spi_sck domain (asynchronous here)
- hdr_start_in  in  1  one-cycle slot start; begin replay
- hdr_abort_in  in  1  one-cycle abort; discard header, return to IDLE
- err_clr_in  in  1  clears sticky errors
- sym_ready_in  in  1  downstream accepts symbol
- sym_valid_out  out  1  symbol valid
- sym_data_out  out  SYM_W  pulse symbol
- sym_last_out  out  1  marks symbol 31
- hdr_ready_out  out  1  all 8 words held, awaiting start
- word_cnt_out  out  4  number of distinct words received (0..8)
- hdr_err_out  out  2  sticky: [0] bad address/overrun write, [1] start without full header
- debug_signal  out  64  {state, valid_mask, sym_idx, sync regs, err}, no functional use

## Operation
- Strobe sync: spi_ram_wr_in → 2-flop synchronizer → edge register; rising edge yields 1-cycle wr_pulse. Addr/data sampled directly on wr_pulse (held stable by upstream for a full SPI word).
- Register file mem[0..7] × 32; valid_mask[7:0]; word_cnt_out = popcount(valid_mask).
- FSM states IDLE, FILL, FULL, SEND:
  - IDLE: mask=0. Valid write (addr 1..8) → mem[addr-1] written, mask bit set, → FILL.
  - FILL: valid writes store/overwrite (duplicate address: overwrite, no error). Mask==FF → FULL.
  - FULL: hdr_ready_out=1. hdr_start_in → SEND, sym_idx=0.
  - SEND: symbol i = mem[i>>2] byte (3 − i[1:0]) bits [SYM_W-1:0] (MSB byte first). Advance on valid&&ready; sym_last_out=1 when sym_idx=31; acceptance of last → IDLE, mask cleared.
- Writes with addr 0 or >8 in any state: dropped, err[0] set. Writes in FULL or SEND: dropped (header protected), err[0] set.
- hdr_start_in in IDLE/FILL: ignored, err[1] set. In SEND: ignored, no error.
- hdr_abort_in (any state): → IDLE, mask cleared, sym_valid_out drops next cycle; abort has priority over start and writes in the same cycle.
- err_clr_in clears both bits; a same-cycle new error wins (bit stays set).

## Timing
- Reset values: sym_valid_out=0, sym_data_out=0, sym_last_out=0, hdr_ready_out=0, word_cnt_out=0, hdr_err_out=0, debug_signal=0; state IDLE; mem contents don't-care.
- Write latency: mem/mask updated on the 3rd logic_clk_in edge after spi_ram_wr_in rises (2 sync + edge). word_cnt_out updates with the mask.
- hdr_ready_out rises 1 cycle after the 8th distinct write commits.
- hdr_start_in at cycle T → sym_valid_out=1 with symbol 0 at T+1; hdr_ready_out low at T+1.
- Symbols registered; valid held and data stable while sym_ready_in=0. With ready held high, 32 symbols in 32 consecutive cycles.
- Last accepted at cycle L → IDLE at L+1; a write committing at L+1 is accepted into a fresh frame.

## Test plan
- Reset mid-SEND (rst_n low at symbol 10) → all outputs 0 immediately, state IDLE after release, word_cnt_out=0.
- Write 8 words 0x5555AAAA..0x0000001F at addr 1..8, ready high, start → 32 symbols; words 0 → 0x15,0x15,0x0A,0x0A; last asserted only on symbol 31; hdr_ready_out low throughout SEND.
- Random sym_ready_in (50% duty) on the same header → identical symbol sequence, no drops/duplicates, valid never falls before acceptance.
- Write addr 0 and addr 9 → err=01, word_cnt_out unchanged; start with 7 words → err=11, no symbols; err_clr_in → 00.
- Full header, then rewrite addr 3 with 0xFFFFFFFF before start → err[0]=1, replay carries the original word 3.
- Abort at symbol 5 with same-cycle start → IDLE, valid low next cycle, mask 0; subsequent fresh 8-word fill replays correctly.
